dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder side of the memory-stage data-memory interface.
- Accepts one load/store request at a time from the memory stage over a valid/ready handshake.
- Models a fixed multi-cycle access latency and returns read data with a one-cycle response strobe.
- Drives a stall to the hazard unit while an access is outstanding; replaces the single-cycle combinational data memory behind the memory stage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array.
- BASE_ADDR, 32'h1000_0000, byte address of word 0.
- LATENCY, 2, edges from request acceptance to response (must be >= 1).

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  memory stage presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_be  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i); ignored on loads.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range access; valid with resp_valid.
- stall  output  1  hold the pipeline; to hazard unit.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, stall=0.
- Array contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On an edge with req_valid=1, latch we/be/addr/wdata, load cnt=LATENCY-1, go to BUSY. Otherwise stay in IDLE.
- BUSY: req_ready=0, stall=1.
  - cnt>0: decrement each edge.
  - cnt==0: the next edge performs the access and goes to RESP.
- RESP: resp_valid=1 for exactly one cycle; req_ready=0, stall=0. Next edge goes to IDLE unconditionally.
- Latency: request accepted at edge k gives resp_valid high in the cycle between edges k+LATENCY and k+LATENCY+1.
  - Back-to-back requests therefore have one idle cycle between RESP and the next acceptance.
- stall is asserted exactly while in BUSY (LATENCY cycles per access).
- Address decode: off = addr - BASE_ADDR (32-bit unsigned); word index = off[31:2].
  - Error if addr[1:0] != 0, or addr < BASE_ADDR, or off >= DEPTH_WORDS*4.
  - On error: no array read or write, resp_err=1, resp_rdata=0, same latency as a good access.
- Store: at the access edge, write only the byte lanes with be set. resp_rdata=0, resp_err=0.
  - be=4'b0000 store: no array change and no error.
- Load: resp_rdata = full word at index, sampled at the access edge; be is ignored.
- Read-after-write: a load accepted after a store's RESP cycle observes the stored data.
- req_valid/req_addr changes while BUSY or RESP are ignored; the latched request is used.
- resp_rdata and resp_err hold their last values outside RESP; consumers use them only with resp_valid.
- Reset mid-operation (BUSY or RESP): immediate return to IDLE, pending access dropped.
  - A pending store that has not reached its access edge is not written.
  - resp_valid and stall deassert asynchronously.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE/BUSY/RESP).
  - word/byte width constants (WORD_W=32, BE_W=4).
  - default BASE_ADDR.
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage.
  - synchronous byte-enabled write.
  - synchronous read on an access strobe.
- The FSM, counter and address decode live in dmem_responder.

Test Plan:
- Reset, then idle with req_valid=0 -> req_ready=1, stall=0, resp_valid=0 indefinitely.
- Store addr=32'h1000_0010, wdata=32'hDEAD_BEEF, be=4'hF at edge k (LATENCY=2) -> stall high during cycles k..k+1, resp_valid high exactly the cycle after edge k+2, resp_err=0, resp_rdata=0.
- Byte-lane merge:
  - Store 32'h1122_3344 to 32'h1000_0020 with be=4'hF.
  - Store 32'hAABB_CCDD to the same address with be=4'b0101.
  - Load the same address -> resp_rdata=32'h11BB_33DD.
- Error paths -> resp_err=1, resp_rdata=0, response after the same LATENCY, no array change (the next valid load of 32'h1000_0010 still returns 32'hDEAD_BEEF):
  - load addr=32'h1000_0002 (misaligned).
  - load addr=32'h0FFF_FFFC (below base).
  - store addr=BASE_ADDR+4*DEPTH_WORDS (above range).
- Hold req_valid=1 continuously with alternating loads -> acceptances every LATENCY+2 cycles, req_ready low from acceptance through RESP, exactly one resp_valid per request.
- Assert reset during BUSY of a store of 32'h0000_0001 to 32'h1000_0030 (word previously 32'h5555_5555) -> state IDLE and stall=0 immediately, no resp_valid, subsequent load returns 32'h5555_5555.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned BE_W   = WORD_W / 8;

   localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-enabled synchronous write and a
// synchronous read register that only updates on a read strobe.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned IDX_W       = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [BE_W-1:0]   be,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] rdata_d;

   // Read data holds between strobes so the responder can present it later.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = mem_q[idx];
      end
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
      if (wr_en) begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request, stalls the
// pipeline for LATENCY cycles, then strobes a single-cycle response.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter logic [WORD_W-1:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned       LATENCY     = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [BE_W-1:0]   req_be,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              stall
);

   localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CNT_W  = $clog2(LATENCY + 1);
   localparam int unsigned SPAN_W = WORD_W + 1;

   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);
   localparam logic [SPAN_W-1:0] SPAN     = SPAN_W'(DEPTH_WORDS) << 2;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [BE_W-1:0]   be_q, be_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              load_ok_q, load_ok_d;

   logic [WORD_W-1:0] off;
   logic              dec_err;
   logic [IDX_W-1:0]  idx;
   logic              acc_rd;
   logic              acc_wr;
   logic [WORD_W-1:0] arr_rdata;

   // The span compare is one bit wider so DEPTH_WORDS*4 cannot wrap.
   always_comb begin
      off     = addr_q - BASE_ADDR;
      dec_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR) ||
                ({1'b0, off} >= SPAN);
      idx     = off[IDX_W+1:2];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      load_ok_d = load_ok_q;
      acc_rd    = 1'b0;
      acc_wr    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               be_d    = req_be;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_INIT;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               acc_rd    = !we_q && !dec_err;
               acc_wr    = we_q && !dec_err;
               err_d     = dec_err;
               load_ok_d = !we_q && !dec_err;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         load_ok_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         load_ok_q <= load_ok_d;
      end
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .wr_en (acc_wr),
      .rd_en (acc_rd),
      .idx   (idx),
      .be    (be_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // Handshake outputs decode the state register so reset clears them at once.
   assign req_ready  = (state_q == ST_IDLE);
   assign stall      = (state_q == ST_BUSY);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = err_q;
   assign resp_rdata = load_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases then random traffic
// against a word-level reference memory.
module tb_dmem_responder;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   (BASE),
      .LATENCY     (LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_be     (req_be),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .stall      (stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit        we;
      bit [3:0]  be;
      bit [31:0] addr;
      bit [31:0] wdata;
      bit [31:0] exp_rdata;
      bit        exp_err;
      int        acc;
   } txn_t;

   txn_t       sb[$];
   bit [31:0]  model[int];
   int         cyc = 0;
   int         last_acc = -1000;
   int         tests = 0;
   int         fails = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic bit ref_err(input bit [31:0] addr);
      longint a;
      a = longint'(addr);
      return (addr % 4 != 0) || (a < longint'(BASE)) ||
             (a - longint'(BASE) >= longint'(DEPTH) * 4);
   endfunction

   function automatic int ref_word(input bit [31:0] addr);
      return int'((longint'(addr) - longint'(BASE)) / 4);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: per-cycle handshake expectations and response scoreboard.
   always @(negedge clk) begin
      bit busy, in_resp;
      busy    = (cyc >= last_acc) && (cyc < last_acc + int'(LAT));
      in_resp = (cyc == last_acc + int'(LAT));
      check("stall", stall, busy);
      check("req_ready", req_ready, !(busy || in_resp));
      check("resp_valid", resp_valid, in_resp);
      if (resp_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_resp", 1, 0);
         end else begin
            txn_t t;
            t = sb.pop_front();
            check("latency", cyc - t.acc, LAT);
            check("resp_err", resp_err, t.exp_err);
            check("resp_rdata", resp_rdata, t.exp_rdata);
            if (t.we && !t.exp_err) begin
               bit [31:0] w;
               int k;
               k = ref_word(t.addr);
               w = model.exists(k) ? model[k] : 32'h0;
               for (int b = 0; b < 4; b++)
                  if (t.be[b]) w[8*b +: 8] = t.wdata[8*b +: 8];
               model[k] = w;
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic issue(input bit we, input bit [3:0] be, input bit [31:0] addr,
                        input bit [31:0] wd, input bit hold);
      txn_t t;
      int n;
      req_valid = 1'b1;
      req_we    = we;
      req_be    = be;
      req_addr  = addr;
      req_wdata = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      t.we = we; t.be = be; t.addr = addr; t.wdata = wd;
      t.exp_err = ref_err(addr);
      t.exp_rdata = 32'h0;
      if (!we && !t.exp_err)
         t.exp_rdata = model.exists(ref_word(addr)) ? model[ref_word(addr)] : 32'h0;
      t.acc = cyc + 1;
      sb.push_back(t);
      last_acc = cyc + 1;
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bit [31:0] a;
      #1 reset = 1'b1;
      idle(2);
      #1;
      check("rst_ready", req_ready, 1);
      check("rst_stall", stall, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_rdata", resp_rdata, 0);
      check("rst_err", resp_err, 0);
      @(negedge clk);
      reset = 1'b0;
      idle(5);

      // Known contents for the first 16 words; word 12 (0x30) is 5555_5555.
      for (int i = 0; i < 16; i++)
         issue(1'b1, 4'hF, BASE + 32'(4 * i), (i == 12) ? 32'h5555_5555 : $urandom, 1'b0);
      drain();

      issue(1'b1, 4'hF, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0);
      drain();
      issue(1'b1, 4'hF, 32'h1000_0020, 32'h1122_3344, 1'b0);
      issue(1'b1, 4'b0101, 32'h1000_0020, 32'hAABB_CCDD, 1'b0);
      issue(1'b0, 4'h0, 32'h1000_0020, 32'h0, 1'b0);
      drain();
      check("merge_model", model[8], 32'h11BB_33DD);

      issue(1'b0, 4'hF, 32'h1000_0002, 32'h0, 1'b0);
      issue(1'b0, 4'hF, 32'h0FFF_FFFC, 32'h0, 1'b0);
      issue(1'b1, 4'hF, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 1'b0);
      issue(1'b0, 4'h0, 32'h1000_0010, 32'h0, 1'b0);
      drain();

      for (int i = 0; i < 6; i++)
         issue(1'b0, 4'h0, (i % 2 == 0) ? 32'h1000_0010 : 32'h1000_0020, 32'h0, 1'b1);
      req_valid = 1'b0;
      drain();
      idle(2);

      // Reset while the store is still in BUSY: it must never land.
      issue(1'b1, 4'hF, 32'h1000_0030, 32'h0000_0001, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("midrst_stall", stall, 0);
      check("midrst_ready", req_ready, 1);
      check("midrst_resp_valid", resp_valid, 0);
      sb.delete();
      last_acc = -1000;
      @(negedge clk);
      reset = 1'b0;
      idle(3);
      issue(1'b0, 4'h0, 32'h1000_0030, 32'h0, 1'b0);
      drain();
      check("midrst_model", model[12], 32'h5555_5555);

      for (int i = 0; i < 80; i++) begin
         int kind;
         bit hold;
         kind = int'($urandom_range(0, 9));
         hold = ($urandom_range(0, 3) == 0);
         a = BASE + 32'(4 * $urandom_range(0, 15));
         if (kind < 4)
            issue(1'b1, 4'($urandom_range(0, 15)), a, $urandom, hold);
         else if (kind < 8)
            issue(1'b0, 4'($urandom_range(0, 15)), a, $urandom, hold);
         else if (kind == 8)
            issue($urandom_range(0, 1) == 1, 4'hF, a + 32'($urandom_range(1, 3)), $urandom, hold);
         else if ($urandom_range(0, 1) == 1)
            issue($urandom_range(0, 1) == 1, 4'hF, BASE - 32'(4 * $urandom_range(1, 8)), $urandom, hold);
         else
            issue($urandom_range(0, 1) == 1, 4'hF, BASE + 32'(4 * (DEPTH + $urandom_range(0, 8))), $urandom, hold);
         if (!hold) begin
            req_valid = 1'b0;
            idle(int'($urandom_range(0, 2)));
         end
      end
      req_valid = 1'b0;
      drain();
      idle(4);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
